// File: rtl/fb_channel_energy_if.sv
// rtl/fb_channel_energy_if.sv - per-channel energy result stream, one channel per beat
interface fb_channel_energy_if #(
  parameter int ACC_W = 31,
  parameter int CH_W  = 4
);
  logic             m_valid;
  logic             m_ready;
  logic [ACC_W-1:0] m_data;
  logic [CH_W-1:0]  m_chan;
  logic             m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_chan,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_chan,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/fb_channel_energy.sv
// rtl/fb_channel_energy.sv - windowed |x| accumulation per filterbank channel, drained as a stream
module fb_channel_energy #(
  parameter int NCH      = 16,
  parameter int IN_W     = 27,
  parameter int LOG2_WIN = 4,
  parameter int ACC_W    = IN_W + LOG2_WIN,
  parameter int CH_W     = 4
) (
  input  logic                clk_en,
  input  logic                reset,
  input  logic                sample_strobe,
  input  logic [NCH*IN_W-1:0] chan_in,
  output logic                overrun,
  input  logic                clear_overrun,
  fb_channel_energy_if.master m_axis
);

  typedef enum logic {IDLE, DRAIN} state_e;

  state_e              state_q, state_d;
  logic [CH_W-1:0]     idx_q, idx_d;
  logic [LOG2_WIN-1:0] wcnt_q, wcnt_d;
  logic                overrun_q, overrun_d;
  logic [ACC_W-1:0]    acc_q [NCH];
  logic [ACC_W-1:0]    acc_d [NCH];
  logic [ACC_W-1:0]    buf_q [NCH];
  logic [ACC_W-1:0]    buf_d [NCH];
  logic [ACC_W-1:0]    sum   [NCH];
  logic [IN_W-1:0]     mag   [NCH];

  logic hs, last_beat, final_hs, complete, accept, drop;

  // Two's-complement negate in IN_W bits: the most negative input yields 2^(IN_W-1) unsigned.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      mag[k] = chan_in[k*IN_W + IN_W - 1] ? (~chan_in[k*IN_W +: IN_W] + 1'b1)
                                          : chan_in[k*IN_W +: IN_W];
      sum[k] = acc_q[k] + ACC_W'(mag[k]);
    end
  end

  always_comb begin
    hs        = (state_q == DRAIN) && m_axis.m_ready;
    last_beat = (idx_q == CH_W'(NCH - 1));
    final_hs  = hs && last_beat;
    complete  = sample_strobe && (wcnt_q == '1);
    accept    = complete && ((state_q == IDLE) || final_hs);
    drop      = complete && !accept;
  end

  always_ff @(posedge clk_en) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      wcnt_q    <= '0;
      overrun_q <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        acc_q[k] <= '0;
        buf_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wcnt_q    <= wcnt_d;
      overrun_q <= overrun_d;
      for (int k = 0; k < NCH; k++) begin
        acc_q[k] <= acc_d[k];
        buf_q[k] <= buf_d[k];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = DRAIN;
      DRAIN:   if (final_hs && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Accumulation proceeds independently of the drain; only the snapshot is gated.
  always_comb begin
    wcnt_d    = wcnt_q;
    idx_d     = idx_q;
    overrun_d = overrun_q;
    for (int k = 0; k < NCH; k++) begin
      acc_d[k] = acc_q[k];
      buf_d[k] = buf_q[k];
    end

    if (sample_strobe) begin
      wcnt_d = wcnt_q + 1'b1;
      for (int k = 0; k < NCH; k++) begin
        acc_d[k] = complete ? '0 : sum[k];
        if (accept) buf_d[k] = sum[k];
      end
    end

    if (accept || final_hs) idx_d = '0;
    else if (hs)            idx_d = idx_q + 1'b1;

    if (drop)               overrun_d = 1'b1;
    else if (clear_overrun) overrun_d = 1'b0;
  end

  always_comb begin
    m_axis.m_valid = 1'b0;
    m_axis.m_data  = '0;
    m_axis.m_chan  = '0;
    m_axis.m_last  = 1'b0;
    if (state_q == DRAIN) begin
      m_axis.m_valid = 1'b1;
      m_axis.m_data  = buf_q[idx_q];
      m_axis.m_chan  = idx_q;
      m_axis.m_last  = last_beat;
    end
  end

  assign overrun = overrun_q;

endmodule

// File: tb/tb_fb_channel_energy.sv
// tb/tb_fb_channel_energy.sv - directed vector bench for fb_channel_energy
module tb_fb_channel_energy;

  localparam int NCH  = 16;
  localparam int IN_W = 27;

  logic                clk_en = 1'b0;
  logic                reset;
  logic                sample_strobe;
  logic [NCH*IN_W-1:0] chan_in;
  logic                overrun;
  logic                clear_overrun;

  int n_cmp  = 0;
  int n_fail = 0;

  fb_channel_energy_if m_if ();

  fb_channel_energy dut (
    .clk_en        (clk_en),
    .reset         (reset),
    .sample_strobe (sample_strobe),
    .chan_in       (chan_in),
    .overrun       (overrun),
    .clear_overrun (clear_overrun),
    .m_axis        (m_if.master)
  );

  always #5 clk_en = ~clk_en;

  typedef struct {
    longint base;
    longint slope;
    longint exp_base;
    longint exp_step;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_chan(input longint base, input longint slope);
    for (int k = 0; k < NCH; k++) chan_in[k*IN_W +: IN_W] = IN_W'(base + slope * k);
  endtask

  // 16 back-to-back strobes; returns at the negedge where the first beat is visible
  task automatic window(input longint base, input longint slope);
    for (int s = 0; s < 16; s++) begin
      @(negedge clk_en);
      sample_strobe = 1'b1;
      set_chan(base, slope);
    end
    @(negedge clk_en);
    sample_strobe = 1'b0;
  endtask

  task automatic drain_check(input string tag, input longint eb, input longint es, input int first);
    for (int b = first; b < NCH; b++) begin
      chk({tag, "_valid"}, longint'(m_if.m_valid), 1);
      chk({tag, "_chan"},  longint'(m_if.m_chan), b);
      chk({tag, "_data"},  longint'(m_if.m_data), eb + es * b);
      chk({tag, "_last"},  longint'(m_if.m_last), (b == NCH - 1) ? 1 : 0);
      chk({tag, "_ovr"},   longint'(overrun), 0);
      @(negedge clk_en);
    end
  endtask

  initial begin
    vecs[0] = '{0,         1,  0,          16};
    vecs[1] = '{-67108864, 0,  1073741824, 0};
    vecs[2] = '{-1,        -1, 16,         16};
    vecs[3] = '{67108863,  0,  1073741808, 0};
    vecs[4] = '{-100,      0,  1600,       0};

    reset         = 1'b1;
    sample_strobe = 1'b0;
    chan_in       = '0;
    clear_overrun = 1'b0;
    m_if.m_ready  = 1'b1;
    repeat (3) @(negedge clk_en);
    reset = 1'b0;
    @(negedge clk_en);
    chk("rst_valid", longint'(m_if.m_valid), 0);
    chk("rst_data",  longint'(m_if.m_data), 0);
    chk("rst_chan",  longint'(m_if.m_chan), 0);
    chk("rst_last",  longint'(m_if.m_last), 0);
    chk("rst_ovr",   longint'(overrun), 0);

    for (int v = 0; v < 5; v++) begin
      window(vecs[v].base, vecs[v].slope);
      drain_check($sformatf("vec%0d", v), vecs[v].exp_base, vecs[v].exp_step, 0);
      chk("vec_idle", longint'(m_if.m_valid), 0);
    end

    // backpressure: stall 5 cycles on chan 0
    m_if.m_ready = 1'b0;
    window(3, 0);
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", longint'(m_if.m_valid), 1);
      chk("bp_chan",  longint'(m_if.m_chan), 0);
      chk("bp_data",  longint'(m_if.m_data), 48);
      chk("bp_last",  longint'(m_if.m_last), 0);
      @(negedge clk_en);
    end
    m_if.m_ready = 1'b1;
    drain_check("bp", 48, 0, 0);
    chk("bp_idle", longint'(m_if.m_valid), 0);

    // overrun: window B dropped while window A is stalled
    m_if.m_ready = 1'b0;
    window(1, 0);
    chk("ovr_a", longint'(overrun), 0);
    window(2, 0);
    chk("ovr_b", longint'(overrun), 1);
    chk("ovr_valid", longint'(m_if.m_valid), 1);
    m_if.m_ready = 1'b1;
    for (int b = 0; b < NCH; b++) begin
      chk("ovr_chan", longint'(m_if.m_chan), b);
      chk("ovr_data", longint'(m_if.m_data), 16);
      chk("ovr_sticky", longint'(overrun), 1);
      @(negedge clk_en);
    end
    chk("ovr_idle", longint'(m_if.m_valid), 0);
    clear_overrun = 1'b1;
    @(negedge clk_en);
    clear_overrun = 1'b0;
    chk("ovr_clear", longint'(overrun), 0);

    // back-to-back: final beat of A coincides with B's completing strobe
    for (int s = 0; s < 16; s++) begin
      @(negedge clk_en);
      sample_strobe = 1'b1;
      set_chan(1, 0);
    end
    for (int s = 0; s < 16; s++) begin
      @(negedge clk_en);
      chk("b2b_a_chan", longint'(m_if.m_chan), s);
      chk("b2b_a_data", longint'(m_if.m_data), 16);
      set_chan(7, 0);
    end
    @(negedge clk_en);
    sample_strobe = 1'b0;
    drain_check("b2b_b", 112, 0, 0);
    chk("b2b_idle", longint'(m_if.m_valid), 0);

    // reset mid-drain with a partial window pending
    window(4, 0);
    for (int b = 0; b < 3; b++) begin
      chk("rmd_chan", longint'(m_if.m_chan), b);
      chk("rmd_data", longint'(m_if.m_data), 64);
      sample_strobe = 1'b1;
      set_chan(9, 0);
      @(negedge clk_en);
    end
    sample_strobe = 1'b0;
    reset = 1'b1;
    @(negedge clk_en);
    reset = 1'b0;
    chk("rmd_valid", longint'(m_if.m_valid), 0);
    chk("rmd_chan0", longint'(m_if.m_chan), 0);
    chk("rmd_data0", longint'(m_if.m_data), 0);
    window(5, 0);
    drain_check("rmd", 80, 0, 0);
    chk("rmd_idle", longint'(m_if.m_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
